// File: rtl/pbch_eq_reader_pkg.sv
// Package pbch_eq_pkg: shared widths, FSM state type and output round/saturate
// helper for the PBCH equalizer reader.
//   H_WIDTH/RX_WIDTH/OUT_WIDTH/H_FRAC : datapath word formats (S0.7, S0.11, S0.11)
//   PROD_W                            : full-precision conj(h)*y width
//   NUM_RE_PBCH                       : PBCH data REs per SSB
//   state_e                           : reader FSM states
//   round_sat()                       : round half up by H_FRAC bits, then clamp
package pbch_eq_pkg;

  localparam int H_WIDTH     = 8;
  localparam int RX_WIDTH    = 12;
  localparam int OUT_WIDTH   = 12;
  localparam int H_FRAC      = 7;
  localparam int PROD_W      = H_WIDTH + RX_WIDTH + 1;
  localparam int NUM_RE_PBCH = 432;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  // Constants held one bit wider than the product so the rounding add cannot wrap.
  localparam logic signed [PROD_W:0] RS_HALF = (PROD_W+1)'(1 << (H_FRAC - 1));
  localparam logic signed [PROD_W:0] RS_MAX  = (PROD_W+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W:0] RS_MIN  = ~RS_MAX;

  function automatic logic signed [OUT_WIDTH-1:0] round_sat(input logic signed [PROD_W-1:0] x);
    logic signed [PROD_W:0]      sum;
    logic signed [PROD_W:0]      shr;
    logic signed [OUT_WIDTH-1:0] res;
    sum = $signed({x[PROD_W-1], x}) + RS_HALF;
    shr = sum >>> H_FRAC;
    if (shr > RS_MAX) begin
      res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (shr < RS_MIN) begin
      res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      res = shr[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pbch_eq_reader_if.sv
// Interface pbch_eq_reader_if: all non-clock/reset signals of the PBCH equalizer
// reader. Optional macro PBCH_EQ_ENERGY_EN adds the h_energy bus.
//   master modport : the reader (drives read port and equalized stream)
//   slave modport  : the environment (estimator/RAMs/demapper)
//
// Handshake rules: ch_avg_done is a one-cycle start pulse honoured only in IDLE.
// eq_read_enable/eq_read_addr ask the RAMs for one word; h and rx for that address
// must be presented exactly one cycle later (no ready, fixed latency). eq_valid
// qualifies eq_i/eq_q/eq_index for one cycle each; the demapper cannot stall it.
interface pbch_eq_reader_if
  import pbch_eq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_RE     = NUM_RE_PBCH
);
  localparam int ENERGY_W = 2 * H_WIDTH + $clog2(NUM_RE);

  logic                        ch_avg_done;
  logic [ADDR_WIDTH-1:0]       eq_read_addr;
  logic                        eq_read_enable;
  logic signed [H_WIDTH-1:0]   i_ch_avg_out;
  logic signed [H_WIDTH-1:0]   q_ch_avg_out;
  logic signed [RX_WIDTH-1:0]  rx_i;
  logic signed [RX_WIDTH-1:0]  rx_q;
  logic signed [OUT_WIDTH-1:0] eq_i;
  logic signed [OUT_WIDTH-1:0] eq_q;
  logic                        eq_valid;
  logic [ADDR_WIDTH-1:0]       eq_index;
  logic                        eq_busy;
  logic                        eq_done;
`ifdef PBCH_EQ_ENERGY_EN
  logic [ENERGY_W-1:0]         h_energy;

  modport master (
    input  ch_avg_done, i_ch_avg_out, q_ch_avg_out, rx_i, rx_q,
    output eq_read_addr, eq_read_enable, eq_i, eq_q, eq_valid, eq_index,
           eq_busy, eq_done, h_energy
  );
  modport slave (
    output ch_avg_done, i_ch_avg_out, q_ch_avg_out, rx_i, rx_q,
    input  eq_read_addr, eq_read_enable, eq_i, eq_q, eq_valid, eq_index,
           eq_busy, eq_done, h_energy
  );
`else
  modport master (
    input  ch_avg_done, i_ch_avg_out, q_ch_avg_out, rx_i, rx_q,
    output eq_read_addr, eq_read_enable, eq_i, eq_q, eq_valid, eq_index,
           eq_busy, eq_done
  );
  modport slave (
    output ch_avg_done, i_ch_avg_out, q_ch_avg_out, rx_i, rx_q,
    input  eq_read_addr, eq_read_enable, eq_i, eq_q, eq_valid, eq_index,
           eq_busy, eq_done
  );
`endif

endinterface

// File: rtl/pbch_eq_reader_cmplx_conj_mult.sv
// Module cmplx_conj_mult: registered conj(a) * b, full precision.
//   clk, rst      : clock, synchronous active-high reset
//   a_re, a_im    : channel estimate h (signed, A_W bits)
//   b_re, b_im    : received RE y (signed, B_W bits)
//   p_re_q, p_im_q: conj(a)*b, A_W+B_W+1 bits, one cycle after the inputs
module cmplx_conj_mult #(
  parameter int A_W = 8,
  parameter int B_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [A_W-1:0]    a_re,
  input  logic signed [A_W-1:0]    a_im,
  input  logic signed [B_W-1:0]    b_re,
  input  logic signed [B_W-1:0]    b_im,
  output logic signed [A_W+B_W:0]  p_re_q,
  output logic signed [A_W+B_W:0]  p_im_q
);
  localparam int P_W = A_W + B_W + 1;

  logic signed [P_W-1:0] p_re_d;
  logic signed [P_W-1:0] p_im_d;

  // (ar - j*ai)(br + j*bi) = (ar*br + ai*bi) + j(ar*bi - ai*br)
  always_comb begin
    p_re_d = P_W'(a_re) * P_W'(b_re) + P_W'(a_im) * P_W'(b_im);
    p_im_d = P_W'(a_re) * P_W'(b_im) - P_W'(a_im) * P_W'(b_re);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_re_q <= '0;
      p_im_q <= '0;
    end else begin
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end

endmodule

// File: rtl/pbch_eq_reader.sv
// Module pbch_eq_reader: on ch_avg_done sweeps NUM_RE estimate/rx RAM addresses
// from START_ADDR (wrapping at 2^ADDR_WIDTH), forms conj(h)*y, rounds/saturates
// to OUT_WIDTH and streams the equalized PBCH REs with their ordinal.
// Optional macro PBCH_EQ_ENERGY_EN: accumulate sum |h|^2 over the sweep on h_energy.
//   clk, rst  : clock, synchronous active-high reset (aborts a sweep, no eq_done)
//   bus       : pbch_eq_reader_if.master (read port, equalized stream, status)
//   dbg_state : current FSM state
// Pipeline: T0 enable/addr, T1 RAM data, T2 products, T3 eq_valid (3 cycles).
module pbch_eq_reader
  import pbch_eq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_RE     = NUM_RE_PBCH,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pbch_eq_reader_if.master      bus,
  output state_e                dbg_state
);
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_RE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(START_ADDR);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       k_q, k_d;
  logic                        v1_q, v1_d;
  logic [ADDR_WIDTH-1:0]       idx1_q, idx1_d;
  logic                        v2_q, v2_d;
  logic [ADDR_WIDTH-1:0]       idx2_q, idx2_d;
  logic                        eq_valid_q, eq_valid_d;
  logic [ADDR_WIDTH-1:0]       eq_index_q, eq_index_d;
  logic signed [OUT_WIDTH-1:0] eq_i_q, eq_i_d;
  logic signed [OUT_WIDTH-1:0] eq_q_q, eq_q_d;
  logic signed [PROD_W-1:0]    prod_re, prod_im;
  logic                        rd_en;
  logic                        start;

  assign rd_en = (state_q == READ);
  assign start = (state_q == IDLE) && bus.ch_avg_done;

  // Sweep control. Start pulses outside IDLE (including the DONE cycle) are dropped.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.ch_avg_done) begin
          state_d = READ;
          k_d     = '0;
        end
      end
      READ: begin
        if (k_q == LAST_K) state_d = DRAIN;
        else               k_d     = k_q + 1'b1;
      end
      DRAIN: begin
        if (eq_valid_q && (eq_index_q == LAST_K)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM data lands in T1 and is consumed by the multiplier register directly.
  cmplx_conj_mult #(.A_W(H_WIDTH), .B_W(RX_WIDTH)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .a_re   (bus.i_ch_avg_out),
    .a_im   (bus.q_ch_avg_out),
    .b_re   (bus.rx_i),
    .b_im   (bus.rx_q),
    .p_re_q (prod_re),
    .p_im_q (prod_im)
  );

  // Valid/index delay line tracking the data through T1/T2; outputs held at 0 when idle.
  always_comb begin
    v1_d       = rd_en;
    idx1_d     = k_q;
    v2_d       = v1_q;
    idx2_d     = idx1_q;
    eq_valid_d = v2_q;
    eq_index_d = v2_q ? idx2_q : '0;
    eq_i_d     = v2_q ? round_sat(prod_re) : '0;
    eq_q_d     = v2_q ? round_sat(prod_im) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      v1_q       <= 1'b0;
      idx1_q     <= '0;
      v2_q       <= 1'b0;
      idx2_q     <= '0;
      eq_valid_q <= 1'b0;
      eq_index_q <= '0;
      eq_i_q     <= '0;
      eq_q_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      v1_q       <= v1_d;
      idx1_q     <= idx1_d;
      v2_q       <= v2_d;
      idx2_q     <= idx2_d;
      eq_valid_q <= eq_valid_d;
      eq_index_q <= eq_index_d;
      eq_i_q     <= eq_i_d;
      eq_q_q     <= eq_q_d;
    end
  end

`ifdef PBCH_EQ_ENERGY_EN
  localparam int ENERGY_W = 2 * H_WIDTH + $clog2(NUM_RE);

  logic [ENERGY_W-1:0]        acc_q, acc_d;
  logic [ENERGY_W-1:0]        h_energy_q, h_energy_d;
  logic signed [2*H_WIDTH-1:0] sq_i, sq_q;

  // |h|^2 is accumulated as each estimate word arrives, so the running sum is
  // up to date by T2. Squares are non-negative, so zero extension is safe.
  always_comb begin
    sq_i = bus.i_ch_avg_out * bus.i_ch_avg_out;
    sq_q = bus.q_ch_avg_out * bus.q_ch_avg_out;
    acc_d = acc_q;
    if (start) begin
      acc_d = '0;
    end else if (v1_q) begin
      acc_d = acc_q + ENERGY_W'($unsigned(sq_i)) + ENERGY_W'($unsigned(sq_q));
    end
    // Published on entry to DONE so it is valid alongside eq_done.
    h_energy_d = (state_q == DRAIN && state_d == DONE) ? acc_q : h_energy_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      h_energy_q <= '0;
    end else begin
      acc_q      <= acc_d;
      h_energy_q <= h_energy_d;
    end
  end

  assign bus.h_energy = h_energy_q;
`endif

  assign bus.eq_read_enable = rd_en;
  assign bus.eq_read_addr   = rd_en ? (BASE + k_q) : '0;
  assign bus.eq_valid       = eq_valid_q;
  assign bus.eq_index       = eq_index_q;
  assign bus.eq_i           = eq_i_q;
  assign bus.eq_q           = eq_q_q;
  assign bus.eq_busy        = (state_q == READ) || (state_q == DRAIN);
  assign bus.eq_done        = (state_q == DONE);
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_pbch_eq_reader.sv
`timescale 1ns/1ps
module tb_pbch_eq_reader;
  import pbch_eq_pkg::*;

  localparam int AW    = 10;
  localparam int NRE   = 432;
  localparam int START = 700;            // sweep wraps past address 1023
  localparam int DEPTH = 1 << AW;
  localparam int EXP_W = AW + 2 * OUT_WIDTH;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  always #5 clk = ~clk;

  pbch_eq_reader_if #(.ADDR_WIDTH(AW), .NUM_RE(NRE)) bus();

  pbch_eq_reader #(.ADDR_WIDTH(AW), .NUM_RE(NRE), .START_ADDR(START)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- RAM model (1-cycle read latency) ----------------
  int mem_hi[DEPTH];
  int mem_hq[DEPTH];
  int mem_yi[DEPTH];
  int mem_yq[DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      bus.i_ch_avg_out <= '0;
      bus.q_ch_avg_out <= '0;
      bus.rx_i         <= '0;
      bus.rx_q         <= '0;
    end else if (bus.eq_read_enable) begin
      bus.i_ch_avg_out <= H_WIDTH'(mem_hi[bus.eq_read_addr]);
      bus.q_ch_avg_out <= H_WIDTH'(mem_hq[bus.eq_read_addr]);
      bus.rx_i         <= RX_WIDTH'(mem_yi[bus.eq_read_addr]);
      bus.rx_q         <= RX_WIDTH'(mem_yq[bus.eq_read_addr]);
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int     en_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     addr_cnt = 0;
  bit     armed = 1'b0;
  bit     pending_done = 1'b0;
  int     done_cnt = 0;
  int     last_idx = -1;
  longint exp_energy = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: arithmetic straight from the equalizer definition.
  function automatic int ref_round_sat(input int x);
    int r;
    r = (x + (1 << (H_FRAC - 1))) >>> H_FRAC;
    if (r > (1 << (OUT_WIDTH - 1)) - 1) r = (1 << (OUT_WIDTH - 1)) - 1;
    if (r < -(1 << (OUT_WIDTH - 1)))    r = -(1 << (OUT_WIDTH - 1));
    return r;
  endfunction

  task automatic push_expected();
    int a, re, im;
    exp_energy = 0;
    for (int k = 0; k < NRE; k++) begin
      a  = (START + k) % DEPTH;
      re = mem_hi[a] * mem_yi[a] + mem_hq[a] * mem_yq[a];
      im = mem_hi[a] * mem_yq[a] - mem_hq[a] * mem_yi[a];
      exp_q.push_back({AW'(k), OUT_WIDTH'(ref_round_sat(re)), OUT_WIDTH'(ref_round_sat(im))});
      exp_energy += mem_hi[a] * mem_hi[a] + mem_hq[a] * mem_hq[a];
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    bit done_due;
    cyc++;
    if (!rst) begin
      if (bus.eq_read_enable) begin
        if (!armed || addr_cnt >= NRE) begin
          check("rd_en_outside_sweep", bus.eq_read_enable, 0);
        end else begin
          check("rd_addr", bus.eq_read_addr, (START + addr_cnt) % DEPTH);
          addr_cnt++;
          en_q.push_back(cyc);
        end
      end
      done_due     = pending_done;
      pending_done = 1'b0;
      if (bus.eq_valid) begin
        if (exp_q.size() == 0) begin
          check("eq_valid_unexpected", bus.eq_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("eq_index", bus.eq_index, e[EXP_W-1 -: AW]);
          check("eq_i", bus.eq_i, $signed(e[2*OUT_WIDTH-1 -: OUT_WIDTH]));
          check("eq_q", bus.eq_q, $signed(e[OUT_WIDTH-1:0]));
        end
        if (en_q.size() != 0) check("latency_en_to_valid", cyc - en_q.pop_front(), 3);
        check("busy_during_valid", bus.eq_busy, 1);
        last_idx = bus.eq_index;
        if (bus.eq_index == AW'(NRE - 1)) pending_done = 1'b1;
      end
      if (done_due) begin
        check("done_after_last_valid", bus.eq_done, 1);
      end else if (bus.eq_done) begin
        check("done_unexpected", bus.eq_done, 0);
      end
      if (bus.eq_done) begin
        done_cnt++;
        check("busy_low_at_done", bus.eq_busy, 0);
`ifdef PBCH_EQ_ENERGY_EN
        check("h_energy", bus.h_energy, exp_energy);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill(input int hi, input int hq, input int yi, input int yq);
    for (int a = 0; a < DEPTH; a++) begin
      mem_hi[a] = hi; mem_hq[a] = hq; mem_yi[a] = yi; mem_yq[a] = yq;
    end
  endtask

  task automatic fill_rand();
    for (int a = 0; a < DEPTH; a++) begin
      mem_hi[a] = int'($urandom_range(255)) - 128;
      mem_hq[a] = int'($urandom_range(255)) - 128;
      mem_yi[a] = int'($urandom_range(4095)) - 2048;
      mem_yq[a] = int'($urandom_range(4095)) - 2048;
    end
  endtask

  // Call after a posedge (+#1) or a negedge; holds the pulse for one full cycle.
  task automatic pulse_start();
    bus.ch_avg_done = 1'b1;
    @(posedge clk); #1;
    bus.ch_avg_done = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},    bus.eq_read_enable, 0);
    check({tag, "_rd_addr"},  bus.eq_read_addr,   0);
    check({tag, "_valid"},    bus.eq_valid,       0);
    check({tag, "_done"},     bus.eq_done,        0);
    check({tag, "_busy"},     bus.eq_busy,        0);
    check({tag, "_eq_i"},     bus.eq_i,           0);
    check({tag, "_eq_q"},     bus.eq_q,           0);
    check({tag, "_eq_index"}, bus.eq_index,       0);
`ifdef PBCH_EQ_ENERGY_EN
    check({tag, "_h_energy"}, bus.h_energy,       0);
`endif
  endtask

  // One complete sweep; optional extra start mid-sweep and in the eq_done cycle.
  task automatic sweep(input int mid_at, input bit pulse_in_done);
    int base_done, n;
    push_expected();
    addr_cnt  = 0;
    armed     = 1'b1;
    base_done = done_cnt;
    pulse_start();
    if (mid_at > 0) begin
      repeat (mid_at) @(posedge clk);
      #1;
      pulse_start();
    end
    if (pulse_in_done) begin
      n = 0;
      while (!pending_done && n < 3000) begin @(posedge clk); n++; end
      #1;
      pulse_start();
    end
    n = 0;
    while (done_cnt == base_done && n < 3000) begin @(posedge clk); n++; end
    check("done_count", done_cnt - base_done, 1);
    repeat (20) @(posedge clk);
    #1;
    check("addr_count", addr_cnt, NRE);
    check("exp_q_drained", exp_q.size(), 0);
    armed = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, base_done;
    bus.ch_avg_done = 1'b0;
    fill(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    fill(64, 0, 1024, 0);     sweep(0, 0);   // eq = (512, 0)
    fill(0, 64, 1024, 0);     sweep(0, 0);   // eq = (0, -512)
    fill(0, 64, 0, 1024);     sweep(0, 0);   // eq = (512, 0)
    fill(-128, 0, -2048, 0);  sweep(0, 0);   // saturates to 2047
    fill(1, 0, 64, 0);        sweep(0, 0);   // 0.5 LSB rounds up to 1
    fill(64, 64, 1024, 0);    sweep(0, 0);   // energy 432*8192
`ifdef PBCH_EQ_ENERGY_EN
    check("h_energy_directed", exp_energy, 3538944);
`endif
    fill_rand();              sweep(0, 0);
    fill_rand();              sweep(150, 1); // collisions ignored

    // Abort mid-sweep by reset at RE 200.
    fill_rand();
    push_expected();
    addr_cnt = 0;
    armed    = 1'b1;
    last_idx = -1;
    pulse_start();
    n = 0;
    while (last_idx != 200 && n < 3000) begin @(posedge clk); n++; end
    check("reached_re200", last_idx, 200);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    en_q.delete();
    armed        = 1'b0;
    pending_done = 1'b0;
    @(negedge clk);
    check_outputs_zero("abort");
    base_done = done_cnt;
    repeat (500) @(posedge clk);
    check("no_done_after_abort", done_cnt - base_done, 0);
    #1;
    fill_rand();              sweep(0, 0);   // clean restart

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
